// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state type and encodings for the bit-serial subtractor
package serial_sub_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      SHIFT = ST_SHIFT,
      DONE  = ST_DONE
   } state_t;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit combinational full subtractor cell
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   // Difference is the three-way parity; borrow-out when b (plus borrow-in) exceeds a.
   always_comb begin
      d    = a ^ b ^ bin;
      bout = (~a & b) | (~(a ^ b) & bin);
   end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned a-b, LSB first, valid/ready on both sides
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] diff_sr;
   logic             borrow_q;
   logic [CW-1:0]    cnt;
   logic             d_bit;
   logic             bo_bit;

   // The single arithmetic cell, fed by the low bits of the operand shifters.
   full_subtractor u_cell (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (borrow_q),
      .d    (d_bit),
      .bout (bo_bit)
   );

   // Control FSM; handshake flags are registered alongside the state so they never
   // depend combinationally on in_valid or out_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state    <= SHIFT;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            SHIFT: begin
               if (cnt == LAST) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   // Datapath: load operands on accept, then retire one result bit per SHIFT cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr     <= '0;
         b_sr     <= '0;
         diff_sr  <= '0;
         borrow_q <= 1'b0;
         cnt      <= '0;
      end else if (state == IDLE && in_valid) begin
         a_sr     <= a;
         b_sr     <= b;
         diff_sr  <= '0;
         borrow_q <= 1'b0;
         cnt      <= '0;
      end else if (state == SHIFT) begin
         a_sr     <= {1'b0, a_sr[WIDTH-1:1]};
         b_sr     <= {1'b0, b_sr[WIDTH-1:1]};
         diff_sr  <= {d_bit, diff_sr[WIDTH-1:1]};
         borrow_q <= bo_bit;
         cnt      <= cnt + 1'b1;
      end
   end

   // Results come straight from flops; they only change in SHIFT or on accept,
   // so they stay stable for the whole of DONE.
   assign diff   = diff_sr;
   assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         borrow;
   logic         busy;

   int pass_cnt = 0;
   int tot_cnt  = 0;

   logic [W:0] exp_q [$];

   serial_subtractor #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference: plain modular arithmetic and a magnitude compare.
   function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv);
      int unsigned m;
      m = (int'(av) - int'(bv) + (1 << W)) % (1 << W);
      return {(av < bv), m[W-1:0]};
   endfunction

   // Monitor: every output handshake must match the oldest outstanding expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               tot_cnt++;
               $display("FAIL unexpected_result: got diff %0h borrow %0b with nothing outstanding", diff, borrow);
            end else begin
               logic [W:0] e;
               e = exp_q.pop_front();
               chk("result_diff", 32'(diff), 32'(e[W-1:0]));
               chk("result_borrow", 32'(borrow), 32'(e[W]));
            end
         end
      end
   end

   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input int hold, input bit poke);
      logic [W:0] e;
      int lat;
      int guard;
      e = model(av, bv);
      out_ready = (hold == 0);
      guard = 0;
      @(negedge clk);
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      a = av;
      b = bv;
      in_valid = 1'b1;
      @(posedge clk);
      exp_q.push_back(e);
      #1;
      in_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      lat = 1;
      forever begin
         @(negedge clk);
         if (out_valid) break;
         if (lat > 4 * W) break;
         if (poke && lat == 2) begin
            in_valid = 1'b1;
            a = 8'hAA;
            b = 8'h11;
         end else if (poke && lat == 3) begin
            in_valid = 1'b0;
         end
         @(posedge clk);
         lat++;
      end
      chk("latency", 32'(lat), 32'(W + 1));
      chk("busy_in_done", 32'(busy), 32'd1);
      chk("in_ready_in_done", 32'(in_ready), 32'd0);
      if (hold > 0) begin
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_diff", 32'(diff), 32'(e[W-1:0]));
            chk("hold_borrow", 32'(borrow), 32'(e[W]));
            chk("hold_in_ready", 32'(in_ready), 32'd0);
         end
         @(posedge clk);
         #1;
         out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_borrow", 32'(borrow), 32'd0);
      rst_n = 1'b1;

      run_op(8'h05, 8'h03, 0, 1'b0);
      run_op(8'h03, 8'h05, 0, 1'b0);
      run_op(8'h00, 8'h01, 0, 1'b0);
      run_op(8'hFF, 8'hFF, 0, 1'b0);
      run_op(8'h80, 8'h7F, 0, 1'b0);
      run_op(8'h3C, 8'hA5, 5, 1'b0);
      run_op(8'h20, 8'h07, 0, 1'b1);

      // Abort an operation three cycles into SHIFT.
      out_ready = 1'b1;
      @(negedge clk);
      a = 8'h5A;
      b = 8'h33;
      in_valid = 1'b1;
      @(posedge clk);
      exp_q.push_back(model(8'h5A, 8'h33));
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      void'(exp_q.pop_back());
      #1;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_diff", 32'(diff), 32'd0);
      chk("abort_borrow", 32'(borrow), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_op(8'h10, 8'h01, 0, 1'b0);

      for (int i = 0; i < 25; i++) begin
         run_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
      end

      repeat (4) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor that computes `a - b` one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It is the inverse-direction companion to the team's combinational adder cells: a small, area-cheap arithmetic datapath. It sits behind a valid/ready input port and a valid/ready output port, so it can be dropped between stimulus and checker stages.

## Interface
- `WIDTH`, default 8: operand and result width in bits, ≥ 2.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operands `a`/`b` are valid.
- `in_ready` output 1: block can accept operands; high only in IDLE.
- `a` input WIDTH: minuend, unsigned.
- `b` input WIDTH: subtrahend, unsigned.
- `out_valid` output 1: `diff`/`borrow` are valid; high only in DONE.
- `out_ready` input 1: consumer accepts result.
- `diff` output WIDTH: `(a - b) mod 2^WIDTH`, registered.
- `borrow` output 1: final borrow-out, 1 iff `a < b`, registered.
- `busy` output 1: high in SHIFT or DONE.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - Asserts `in_ready = 1`.
  - On `in_valid && in_ready`: load `a_sr <= a`, `b_sr <= b`, `borrow_q <= 0`, `cnt <= 0`, clear the `diff` shift register; go to SHIFT.
- **SHIFT**, each cycle:
  - Takes `a0 = a_sr[0]`, `b0 = b_sr[0]`, `bi = borrow_q`.
  - `d = a0 ^ b0 ^ bi`.
  - `bo = (~a0 & b0) | (~(a0 ^ b0) & bi)`.
  - `diff_sr <= {d, diff_sr[WIDTH-1:1]}`.
  - `a_sr` and `b_sr` shift right, filling with 0.
  - `borrow_q <= bo`, `cnt <= cnt + 1`.
  - When `cnt == WIDTH-1`, go to DONE on that same edge.
- **DONE**
  - `out_valid = 1`; `diff = diff_sr`; `borrow = borrow_q`.
  - Held stable until `out_ready`.
  - On `out_valid && out_ready`, go to IDLE.
- `cnt` width is `$clog2(WIDTH)`. It never wraps past `WIDTH-1` within one operation.
- `in_valid` is ignored outside IDLE. No overlap of operations; no input queuing.
- `a`/`b` are sampled only on the accept edge. Later changes to them have no effect.
- `out_ready` outside DONE is ignored.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE; `a_sr`, `b_sr`, `diff_sr`, `borrow_q`, `cnt` all 0.
  - `out_valid = 0`, `diff = 0`, `borrow = 0`, `busy = 0`.
  - `in_ready = 1`, since it decodes directly from IDLE.
- Accept at edge N. SHIFT occupies edges N+1..N+WIDTH. `out_valid` rises after edge N+WIDTH.
  - Latency is WIDTH+1 cycles, accept to result.
- Minimum initiation interval is WIDTH+2 cycles:
  - DONE lasts at least one cycle.
  - `in_ready` returns the cycle after the output handshake.
- `in_ready`, `out_valid` and `busy` are pure state decodes, with no combinational path from `in_valid`/`out_ready`.
- Reset asserted mid-SHIFT or mid-DONE aborts the operation. No result is ever presented for it.

## Structure
- Package `serial_sub_pkg` holds:
  - the `state_t` enum (IDLE, SHIFT, DONE);
  - the `localparam` encodings.
- Sub-module `full_subtractor`: purely combinational `(a, b, bin) -> (d, bout)`, instantiated once in the datapath.
- Top module holds the FSM, shift registers, counter and borrow flop.

## Test plan
- **Basic subtract:** WIDTH=8, a=0x05, b=0x03, `out_ready=1` → `out_valid` exactly 9 cycles after accept; `diff=0x02`, `borrow=0`.
- **Underflow:** a=0x03, b=0x05 → `diff=0xFE`, `borrow=1`. Also a=0x00, b=0x01 → `diff=0xFF`, `borrow=1`.
- **Corners:** a=b=0xFF → `diff=0x00`, `borrow=0`. a=0x80, b=0x7F → `diff=0x01`, `borrow=0`.
- **Back-pressure:** hold `out_ready=0` for 5 cycles in DONE → `out_valid`, `diff` and `borrow` stable. `in_ready=0` throughout. Raise `out_ready` → IDLE next cycle.
- **Busy ignore:** pulse `in_valid` with a=0xAA, b=0x11 during SHIFT → result still that of the first accepted operands. No second result appears.
- **Reset mid-op:** deassert `rst_n` 3 cycles into SHIFT → all outputs 0 and `in_ready=1` immediately. After release, a=0x10, b=0x01 → `diff=0x0F`, `borrow=0`.
